ppi_strobed_input_port: RTL and testbench

Mode-1 strobed input port of the PPI. A peripheral strobes a byte in on `STB_n`. The block latches it, raises `IBF` and an optional `INTR`, and clears them when the CPU reads the port. `PortLatch` drives the PortA/PortB input of the data-bus read multiplexer directly downstream, which places the selected port on `DATA` according to `A`.

---
 rtl/ppi_strobed_input_port_if.sv | 26 ++
 rtl/ppi_strobed_input_port.sv | 117 +++++++++++
 tb/tb_ppi_strobed_input_port.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ppi_strobed_input_port_if.sv
// Bus bundle for the PPI mode-1 strobed input port: peripheral/CPU side
// (master) drives strobe, data and read controls; the port (slave) returns latch and flags.
interface ppi_strobed_input_port_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] PortIn;
   logic             STB_n;
   logic             CS_n;
   logic             RD_n;
   logic [1:0]       A;
   logic             INTE;
   logic [WIDTH-1:0] PortLatch;
   logic             IBF;
   logic             INTR;
   logic             OVR;

   modport master (
      output PortIn, STB_n, CS_n, RD_n, A, INTE,
      input  PortLatch, IBF, INTR, OVR
   );

   modport slave (
      input  PortIn, STB_n, CS_n, RD_n, A, INTE,
      output PortLatch, IBF, INTR, OVR
   );
endinterface

// File: rtl/ppi_strobed_input_port.sv
// PPI mode-1 strobed input port: latches a byte on the STB_n falling edge, tracks IBF/INTR/OVR.
// Define PPI_IN_SYNC_EN to pass STB_n and the read strobe through two-flop synchronizers.
module ppi_strobed_input_port #(
   parameter int unsigned WIDTH     = 8,
   parameter logic [1:0]  PORT_ADDR = 2'b00
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ppi_strobed_input_port_if.slave  bus
);
   typedef enum logic [1:0] {EMPTY, FULL, READ} state_e;

   logic rd_act;
   logic stb_s, rd_s, primed;

   assign rd_act = ~bus.CS_n & ~bus.RD_n & (bus.A == PORT_ADDR);

`ifdef PPI_IN_SYNC_EN
   logic       stb_m_q, stb_s_q, rd_m_q, rd_s_q;
   logic [1:0] prime_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb_m_q <= 1'b1;
         stb_s_q <= 1'b1;
         rd_m_q  <= 1'b0;
         rd_s_q  <= 1'b0;
         prime_q <= '0;
      end else begin
         stb_m_q <= bus.STB_n;
         stb_s_q <= stb_m_q;
         rd_m_q  <= rd_act;
         rd_s_q  <= rd_m_q;
         prime_q <= {prime_q[0], 1'b1};
      end
   end

   assign stb_s  = stb_s_q;
   assign rd_s   = rd_s_q;
   assign primed = prime_q[1];
`else
   assign stb_s  = bus.STB_n;
   assign rd_s   = rd_act;
   assign primed = 1'b1;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] latch_q, latch_d;
   logic             ovr_q, ovr_d;
   logic             pend_q, pend_d;
   logic             intr_q, intr_d;
   logic             stb_d_q, rd_d_q;
   logic             arm_q, arm_d;
   logic             stb_fall, rd_fall, rd_rise;

   // A strobe held low across reset must not load: edges count only once a
   // genuine high level has been sampled after the synchronizer has flushed.
   assign arm_d    = arm_q | (primed & stb_s);
   assign stb_fall = arm_q & stb_d_q & ~stb_s;
   assign rd_fall  = ~rd_d_q & rd_s;
   assign rd_rise  = rd_d_q & ~rd_s;

   always_comb begin
      state_d = state_q;
      latch_d = latch_q;
      ovr_d   = ovr_q;
      pend_d  = pend_q;
      if (stb_fall) latch_d = bus.PortIn;
      case (state_q)
         EMPTY: begin
            if (stb_fall) state_d = FULL;
         end
         FULL: begin
            if (stb_fall) ovr_d = 1'b1;
            if (rd_fall) state_d = READ;
         end
         READ: begin
            if (rd_rise) begin
               state_d = (pend_q || stb_fall) ? FULL : EMPTY;
               ovr_d   = 1'b0;
               pend_d  = 1'b0;
            end else if (stb_fall) begin
               pend_d = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      intr_d = bus.INTE & (state_d == FULL) & stb_s & ~rd_fall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         latch_q <= '0;
         ovr_q   <= 1'b0;
         pend_q  <= 1'b0;
         intr_q  <= 1'b0;
         stb_d_q <= 1'b1;
         rd_d_q  <= 1'b0;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         latch_q <= latch_d;
         ovr_q   <= ovr_d;
         pend_q  <= pend_d;
         intr_q  <= intr_d;
         stb_d_q <= stb_s;
         rd_d_q  <= rd_s;
         arm_q   <= arm_d;
      end
   end

   assign bus.PortLatch = latch_q;
   assign bus.IBF       = (state_q != EMPTY);
   assign bus.INTR      = intr_q;
   assign bus.OVR       = ovr_q;
endmodule

// File: tb/tb_ppi_strobed_input_port.sv
// Directed bench for ppi_strobed_input_port (default build): expected outputs
// are queued as stimulus is applied and compared when the port responds.
module tb_ppi_strobed_input_port;
   logic clk;
   logic rst_n;

   ppi_strobed_input_port_if #(.WIDTH(8)) bus ();

   ppi_strobed_input_port #(.WIDTH(8), .PORT_ADDR(2'b00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] latch;
      logic       ibf;
      logic       intr;
      logic       ovr;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input string tag, input logic [7:0] latch, input logic ibf,
                       input logic intr, input logic ovr);
      exp_t e;
      e.tag = tag; e.latch = latch; e.ibf = ibf; e.intr = intr; e.ovr = ovr;
      sb_q.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      checks++;
      assert (sb_q.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard_empty: got 0 entries expected >=1");
      end
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         checks++;
         assert (bus.PortLatch === e.latch) else begin
            errors++;
            $error("FAIL %s.PortLatch: got %0d expected %0d", e.tag, bus.PortLatch, e.latch);
         end
         checks++;
         assert (bus.IBF === e.ibf) else begin
            errors++;
            $error("FAIL %s.IBF: got %b expected %b", e.tag, bus.IBF, e.ibf);
         end
         checks++;
         assert (bus.INTR === e.intr) else begin
            errors++;
            $error("FAIL %s.INTR: got %b expected %b", e.tag, bus.INTR, e.intr);
         end
         checks++;
         assert (bus.OVR === e.ovr) else begin
            errors++;
            $error("FAIL %s.OVR: got %b expected %b", e.tag, bus.OVR, e.ovr);
         end
      end
   endtask

   task automatic strobe(input logic [7:0] v, input int low);
      bus.PortIn = v;
      bus.STB_n  = 1'b0;
      tick(low);
      bus.STB_n  = 1'b1;
      tick(2);
   endtask

   task automatic cpu_read(input logic [1:0] addr, input int low);
      bus.CS_n = 1'b0;
      bus.A    = addr;
      bus.RD_n = 1'b0;
      tick(low);
      bus.RD_n = 1'b1;
      tick(1);
      bus.CS_n = 1'b1;
      bus.A    = 2'b00;
      tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      bus.PortIn = 8'hFF;
      bus.STB_n  = 1'b0;
      bus.CS_n   = 1'b1;
      bus.RD_n   = 1'b1;
      bus.A      = 2'b00;
      bus.INTE   = 1'b0;
      tick(2);

      push("reset", 8'd0, 1'b0, 1'b0, 1'b0);
      check_pop();
      rst_n = 1'b1;
      tick(3);
      push("held_strobe", 8'd0, 1'b0, 1'b0, 1'b0);
      check_pop();
      bus.STB_n = 1'b1;
      bus.INTE  = 1'b1;
      tick(2);

      bus.PortIn = 8'd20;
      bus.STB_n  = 1'b0;
      push("load_E0", 8'd20, 1'b1, 1'b0, 1'b0);
      tick(1);
      check_pop();
      tick(3);
      bus.STB_n = 1'b1;
      push("load_intr", 8'd20, 1'b1, 1'b1, 1'b0);
      tick(1);
      check_pop();
      tick(1);

      bus.CS_n = 1'b0;
      bus.A    = 2'b00;
      bus.RD_n = 1'b0;
      push("read_fall", 8'd20, 1'b1, 1'b0, 1'b0);
      tick(1);
      check_pop();
      tick(3);
      bus.RD_n = 1'b1;
      push("read_rise", 8'd20, 1'b0, 1'b0, 1'b0);
      tick(1);
      check_pop();
      bus.CS_n = 1'b1;
      tick(1);

      strobe(8'd30, 3);
      strobe(8'd50, 3);
      push("overrun", 8'd50, 1'b1, 1'b1, 1'b1);
      check_pop();
      cpu_read(2'b00, 3);
      push("overrun_read", 8'd50, 1'b0, 1'b0, 1'b0);
      check_pop();

      strobe(8'd60, 3);
      bus.CS_n = 1'b0;
      bus.A    = 2'b00;
      bus.RD_n = 1'b0;
      tick(2);
      bus.PortIn = 8'd77;
      bus.STB_n  = 1'b0;
      tick(3);
      bus.STB_n  = 1'b1;
      tick(2);
      push("stb_in_read", 8'd77, 1'b1, 1'b0, 1'b0);
      check_pop();
      bus.RD_n = 1'b1;
      push("pend_refull", 8'd77, 1'b1, 1'b1, 1'b0);
      tick(1);
      check_pop();
      bus.CS_n = 1'b1;
      tick(1);

      bus.CS_n = 1'b0;
      bus.A    = 2'b10;
      bus.RD_n = 1'b0;
      tick(3);
      push("wrong_addr_low", 8'd77, 1'b1, 1'b1, 1'b0);
      check_pop();
      bus.RD_n = 1'b1;
      tick(1);
      bus.CS_n = 1'b1;
      bus.A    = 2'b00;
      tick(1);
      push("wrong_addr_end", 8'd77, 1'b1, 1'b1, 1'b0);
      check_pop();
      cpu_read(2'b00, 3);
      push("drain", 8'd77, 1'b0, 1'b0, 1'b0);
      check_pop();

      bus.INTE = 1'b0;
      strobe(8'd99, 3);
      push("inte_off", 8'd99, 1'b1, 1'b0, 1'b0);
      check_pop();
      bus.INTE = 1'b1;
      push("inte_on", 8'd99, 1'b1, 1'b1, 1'b0);
      tick(1);
      check_pop();
      bus.INTE = 1'b0;
      push("inte_drop", 8'd99, 1'b1, 1'b0, 1'b0);
      tick(1);
      check_pop();

      checks++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover: got %0d expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
